// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
package disp_pkg;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } disp_state_e;

    // One-hot grant encodings
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/disp_hold_timer.sv
// Saturating hold counter; expired flags that the minimum hold time has elapsed.
module disp_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count while enabled, stick at the last value, restart on clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CntLast)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin arbiter sharing one 4-digit display between two requesters,
// with a minimum hold time before the current owner can be preempted.
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic        blank,
    output logic        switch_pulse
);

    disp_state_e state_q, state_d;
    logic        last_q, last_d;
    logic        hold_clear, hold_en, hold_expired;

    logic [1:0]  grant_q, grant_d;
    logic [15:0] hex_q, hex_d;
    logic        blank_q, blank_d;
    logic        pulse_q, pulse_d;

    disp_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (hold_clear),
        .enable  (hold_en),
        .expired (hold_expired)
    );

    // State and round-robin history registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: hold while owner requests, release immediately when it drops
    always_comb begin
        state_d = state_q;
        hold_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_d = ST_OWN0;
                end else if (req1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (req0) begin
                    if (req1 && hold_expired) state_d = ST_OWN1;
                    else                      hold_en = 1'b1;
                end else begin
                    state_d = req1 ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (req1) begin
                    if (req0 && hold_expired) state_d = ST_OWN0;
                    else                      hold_en = 1'b1;
                end else begin
                    state_d = req0 ? ST_OWN0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Any ownership change restarts the hold window
        hold_clear = (state_d != state_q);
    end

    // Remember the most recent owner for tie-breaking from idle
    always_comb begin
        last_d = last_q;
        if (state_d == ST_OWN0)      last_d = 1'b0;
        else if (state_d == ST_OWN1) last_d = 1'b1;
    end

    // Outputs decoded from the next state so grant and digits always agree
    always_comb begin
        grant_d = GRANT_NONE;
        hex_d   = 16'h0000;
        blank_d = 1'b1;
        pulse_d = (state_d != state_q);
        unique case (state_d)
            ST_OWN0: begin
                grant_d = GRANT_0;
                hex_d   = data0;
                blank_d = 1'b0;
            end
            ST_OWN1: begin
                grant_d = GRANT_1;
                hex_d   = data1;
                blank_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q <= GRANT_NONE;
            hex_q   <= 16'h0000;
            blank_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            hex_q   <= hex_d;
            blank_q <= blank_d;
            pulse_q <= pulse_d;
        end
    end

    assign grant        = grant_q;
    assign hex0         = hex_q[3:0];
    assign hex1         = hex_q[7:4];
    assign hex2         = hex_q[11:8];
    assign hex3         = hex_q[15:12];
    assign blank        = blank_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter: HOLD_CYCLES=4 main instance plus a
// HOLD_CYCLES=1 instance for the strict-alternation corner.
module tb_disp_share_arbiter;

    logic        clk;
    logic        resetn;
    logic        req0, req1;
    logic [15:0] data0, data1;

    logic [1:0]  grant, grant_b;
    logic [3:0]  hex0, hex1, hex2, hex3;
    logic [3:0]  hex0_b, hex1_b, hex2_b, hex3_b;
    logic        blank, blank_b;
    logic        switch_pulse, switch_pulse_b;

    int checks = 0;
    int errors = 0;

    // {grant, blank, switch_pulse, hex3, hex2, hex1, hex0}
    logic [19:0] obs, exp_v;

    disp_share_arbiter #(
        .HOLD_CYCLES (4),
        .CNT_W       (3)
    ) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .req0         (req0),
        .data0        (data0),
        .req1         (req1),
        .data1        (data1),
        .grant        (grant),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .blank        (blank),
        .switch_pulse (switch_pulse)
    );

    disp_share_arbiter #(
        .HOLD_CYCLES (1),
        .CNT_W       (1)
    ) u_dut_h1 (
        .clk          (clk),
        .resetn       (resetn),
        .req0         (req0),
        .data0        (data0),
        .req1         (req1),
        .data1        (data1),
        .grant        (grant_b),
        .hex0         (hex0_b),
        .hex1         (hex1_b),
        .hex2         (hex2_b),
        .hex3         (hex3_b),
        .blank        (blank_b),
        .switch_pulse (switch_pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0   = 1'b0;
        req1   = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 16'h0000; data1 = 16'h0000;
        repeat (2) tick();
        resetn = 1'b0;
        #2;
        obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
        exp_v = {2'b00, 1'b1, 1'b0, 16'h0000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, exp_v);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
            exp_v = {2'b00, 1'b1, 1'b0, 16'h0000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_owner();
        logic [19:0] exp_tab [5];
        exp_tab[0] = {2'b01, 1'b0, 1'b1, 16'h1234};
        exp_tab[1] = {2'b01, 1'b0, 1'b0, 16'h1234};
        exp_tab[2] = {2'b01, 1'b0, 1'b0, 16'hABCD};
        exp_tab[3] = {2'b00, 1'b1, 1'b1, 16'h0000};
        exp_tab[4] = {2'b00, 1'b1, 1'b0, 16'h0000};
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin req0 = 1'b1; data0 = 16'h1234; end
                2: data0 = 16'hABCD;
                3: req0 = 1'b0;
                default: ;
            endcase
            tick();
            obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
            checks++;
            if (obs !== exp_tab[i]) begin
                errors++;
                $display("FAIL single_owner step %0d: got %h expected %h", i, obs, exp_tab[i]);
            end
        end
    endtask

    // Both requesting: 4-cycle alternation on the main DUT, every-cycle on the
    // HOLD_CYCLES=1 DUT; digits must always match the granted owner.
    task automatic test_alternation();
        logic [19:0] exp_b;
        do_reset();
        data0 = 16'h1111;
        data1 = 16'h2222;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (((c / 4) % 2) == 0) exp_v = {2'b01, 1'b0, (c % 4) == 0, 16'h1111};
            else                    exp_v = {2'b10, 1'b0, (c % 4) == 0, 16'h2222};
            obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL alternation cyc %0d: got %h expected %h", c, obs, exp_v);
            end
            if ((c % 2) == 0) exp_b = {2'b01, 1'b0, 1'b1, 16'h1111};
            else              exp_b = {2'b10, 1'b0, 1'b1, 16'h2222};
            obs = {grant_b, blank_b, switch_pulse_b, hex3_b, hex2_b, hex1_b, hex0_b};
            checks++;
            if (obs !== exp_b) begin
                errors++;
                $display("FAIL hold1_alternation cyc %0d: got %h expected %h", c, obs, exp_b);
            end
        end
    endtask

    task automatic test_release();
        logic [19:0] exp_tab [4];
        exp_tab[0] = {2'b01, 1'b0, 1'b1, 16'h1111};
        exp_tab[1] = {2'b01, 1'b0, 1'b0, 16'h1111};
        exp_tab[2] = {2'b10, 1'b0, 1'b1, 16'h2222};
        exp_tab[3] = {2'b00, 1'b1, 1'b1, 16'h0000};
        do_reset();
        data0 = 16'h1111;
        data1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: req0 = 1'b1;
                2: begin req0 = 1'b0; req1 = 1'b1; end
                3: req1 = 1'b0;
                default: ;
            endcase
            tick();
            obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
            checks++;
            if (obs !== exp_tab[i]) begin
                errors++;
                $display("FAIL release step %0d: got %h expected %h", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data0 = 16'h1111;
        data1 = 16'h2222;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (5) tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_pre grant: got %b expected 10", grant);
        end
        resetn = 1'b0;
        #2;
        obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
        exp_v = {2'b00, 1'b1, 1'b0, 16'h0000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, exp_v);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        obs = {grant, blank, switch_pulse, hex3, hex2, hex1, hex0};
        exp_v = {2'b01, 1'b0, 1'b1, 16'h1111};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_regrant: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_alternation();
        test_release();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
